// File: rtl/dmi_boot_pkg.sv
// Shared DMI types, debug-module register map and state encodings for the
// self-contained boot sequencer.
package dmi_boot_pkg;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [6:0] DMCONTROL  = 7'h10;
  localparam logic [6:0] DMSTATUS   = 7'h11;
  localparam logic [6:0] DATA0      = 7'h04;
  localparam logic [6:0] DATA1      = 7'h05;
  localparam logic [6:0] ABSTRACTCS = 7'h16;
  localparam logic [6:0] COMMAND    = 7'h17;

  localparam int unsigned DMCTRL_HALTREQ      = 31;
  localparam int unsigned DMCTRL_RESUMEREQ    = 30;
  localparam int unsigned DMCTRL_DMACTIVE     = 0;
  localparam int unsigned DMSTAT_ALLHALTED    = 9;
  localparam int unsigned DMSTAT_ALLRESUMEACK = 17;
  localparam int unsigned ACS_BUSY            = 12;
  localparam int unsigned ACS_CMDERR_LSB      = 8;

  localparam logic [15:0] REGNO_DPC = 16'h07B1;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_DMI_RESP  = 3'd1;
  localparam logic [2:0] ERR_HALT_TO   = 3'd2;
  localparam logic [2:0] ERR_CMDERR    = 3'd3;
  localparam logic [2:0] ERR_ABS_TO    = 3'd4;
  localparam logic [2:0] ERR_RESUME_TO = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ACT   = 4'd1,
    S_HALT  = 4'd2,
    S_WHALT = 4'd3,
    S_CLRH  = 4'd4,
    S_LOAD  = 4'd5,
    S_D0    = 4'd6,
    S_D1    = 4'd7,
    S_CMD   = 4'd8,
    S_WCMD  = 4'd9,
    S_RES   = 4'd10,
    S_WRES  = 4'd11,
    S_FIN   = 4'd12,
    S_DONE  = 4'd13,
    S_ERR   = 4'd14
  } boot_state_e;

  typedef enum logic [1:0] {
    X_IDLE = 2'd0,
    X_REQ  = 2'd1,
    X_RSP  = 2'd2
  } xact_state_e;

  function automatic logic [31:0] dmcontrol_word(input logic haltreq,
                                                 input logic resumereq,
                                                 input logic [19:0] hartsel);
    logic [31:0] w;
    w                   = '0;
    w[DMCTRL_HALTREQ]   = haltreq;
    w[DMCTRL_RESUMEREQ] = resumereq;
    w[25:16]            = hartsel[9:0];
    w[15:6]             = hartsel[19:10];
    w[DMCTRL_DMACTIVE]  = 1'b1;
    return w;
  endfunction

  // Access-register command: transfer=1, write=1, regno=DPC, aarsize by XLEN.
  function automatic logic [31:0] command_word(input int unsigned xlen);
    logic [31:0] w;
    w        = '0;
    w[22:20] = (xlen == 64) ? 3'd3 : 3'd2;
    w[17]    = 1'b1;
    w[16]    = 1'b1;
    w[15:0]  = REGNO_DPC;
    return w;
  endfunction

endpackage

// File: rtl/dmi_boot_sequencer_xact.sv
// Single-outstanding DMI request/response engine. A request presented with
// start_i while idle is driven the same cycle; done_o flags the response.
module dmi_xact
  import dmi_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  addr_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] wdata_i,
  output logic        idle_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [40:0] req_o,
  input  logic        resp_valid_i,
  output logic        resp_ready_o,
  input  logic [33:0] resp_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  resp_o,
  output logic        done_o
);

  xact_state_e state_q;
  dmi_req_t    req_q;
  dmi_req_t    req_new;
  dmi_resp_t   rsp;
  logic        launch;

  assign req_new = '{addr: addr_i, op: op_i, data: wdata_i};
  assign rsp     = resp_i;
  assign launch  = (state_q == X_IDLE) && start_i;

  // Launch cycle drives the fresh request directly so a zero-wait DM
  // completes a write in two cycles; stalls then hold the latched copy.
  assign req_valid_o  = launch || (state_q == X_REQ);
  assign req_o        = (state_q == X_REQ) ? req_q : req_new;
  assign resp_ready_o = (state_q == X_RSP);
  assign done_o       = (state_q == X_RSP) && resp_valid_i;
  assign rdata_o      = rsp.data;
  assign resp_o       = rsp.resp;
  assign idle_o       = (state_q == X_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= X_IDLE;
      req_q   <= '0;
    end else begin
      case (state_q)
        X_IDLE: if (start_i) begin
          req_q   <= req_new;
          state_q <= req_ready_i ? X_RSP : X_REQ;
        end
        X_REQ:   if (req_ready_i)  state_q <= X_RSP;
        X_RSP:   if (resp_valid_i) state_q <= X_IDLE;
        default: state_q <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dmi_boot_sequencer.sv
// Boot sequencer: activates the DM, halts the hart, waits for the memory
// loader, writes DPC through an abstract command and resumes the hart.
module dmi_boot_sequencer
  import dmi_boot_pkg::*;
#(
  parameter logic [63:0] BootAddr    = 64'h8000_0080,
  parameter int unsigned XLEN        = 64,
  parameter logic [19:0] HartSel     = 20'd0,
  parameter logic [15:0] PollTimeout = 16'd4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i,
  output logic        load_req_o,
  input  logic        load_done_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  error_code_o
);

  boot_state_e state_q, state_n;
  logic [15:0] poll_cnt_q;
  logic [2:0]  err_code_q, err_code_n;
  logic        poll_expired;

  logic        dmi_step;
  logic        x_start, x_idle, x_done;
  logic [6:0]  x_addr;
  logic [1:0]  x_op;
  logic [31:0] x_wdata, x_rdata;
  logic [1:0]  x_resp;

  assign poll_expired = (poll_cnt_q == PollTimeout - 16'd1);
  assign x_start      = dmi_step && x_idle;

  always_comb begin
    dmi_step = 1'b1;
    x_addr   = DMCONTROL;
    x_op     = DMI_OP_WRITE;
    x_wdata  = '0;
    case (state_q)
      S_ACT:   x_wdata = 32'h0000_0001;
      S_HALT:  x_wdata = dmcontrol_word(1'b1, 1'b0, HartSel);
      S_WHALT: begin x_addr = DMSTATUS;   x_op = DMI_OP_READ; end
      S_CLRH:  x_wdata = dmcontrol_word(1'b0, 1'b0, HartSel);
      S_D0:    begin x_addr = DATA0;   x_wdata = BootAddr[31:0];  end
      S_D1:    begin x_addr = DATA1;   x_wdata = BootAddr[63:32]; end
      S_CMD:   begin x_addr = COMMAND; x_wdata = command_word(XLEN); end
      S_WCMD:  begin x_addr = ABSTRACTCS; x_op = DMI_OP_READ; end
      S_RES:   x_wdata = dmcontrol_word(1'b0, 1'b1, HartSel);
      S_WRES:  begin x_addr = DMSTATUS;   x_op = DMI_OP_READ; end
      S_FIN:   x_wdata = dmcontrol_word(1'b0, 1'b0, HartSel);
      default: dmi_step = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state_q;
    err_code_n = err_code_q;
    case (state_q)
      S_IDLE: if (start_i) state_n = S_ACT;
      S_LOAD: if (load_done_i) state_n = S_D0;
      S_DONE, S_ERR: ;
      default: if (x_done) begin
        if (x_resp != 2'd0) begin
          state_n    = S_ERR;
          err_code_n = ERR_DMI_RESP;
        end else begin
          case (state_q)
            S_ACT:  state_n = S_HALT;
            S_HALT: state_n = S_WHALT;
            S_WHALT: begin
              if (x_rdata[DMSTAT_ALLHALTED]) state_n = S_CLRH;
              else if (poll_expired) begin
                state_n    = S_ERR;
                err_code_n = ERR_HALT_TO;
              end
            end
            S_CLRH: state_n = S_LOAD;
            S_D0:   state_n = (XLEN == 64) ? S_D1 : S_CMD;
            S_D1:   state_n = S_CMD;
            S_CMD:  state_n = S_WCMD;
            S_WCMD: begin
              if (!x_rdata[ACS_BUSY]) begin
                if (x_rdata[ACS_CMDERR_LSB +: 3] != 3'd0) begin
                  state_n    = S_ERR;
                  err_code_n = ERR_CMDERR;
                end else begin
                  state_n = S_RES;
                end
              end else if (poll_expired) begin
                state_n    = S_ERR;
                err_code_n = ERR_ABS_TO;
              end
            end
            S_RES: state_n = S_WRES;
            S_WRES: begin
              if (x_rdata[DMSTAT_ALLRESUMEACK]) state_n = S_FIN;
              else if (poll_expired) begin
                state_n    = S_ERR;
                err_code_n = ERR_RESUME_TO;
              end
            end
            S_FIN:   state_n = S_DONE;
            default: state_n = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Any state change clears the counter, so every wait state starts from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      err_code_q <= ERR_NONE;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_n;
      err_code_q <= err_code_n;
      if (state_n != state_q)              poll_cnt_q <= '0;
      else if (x_done && poll_cnt_q != '1) poll_cnt_q <= poll_cnt_q + 16'd1;
    end
  end

  dmi_xact u_xact (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (x_start),
    .addr_i       (x_addr),
    .op_i         (x_op),
    .wdata_i      (x_wdata),
    .idle_o       (x_idle),
    .req_valid_o  (dmi_req_valid_o),
    .req_ready_i  (dmi_req_ready_i),
    .req_o        (dmi_req_o),
    .resp_valid_i (dmi_resp_valid_i),
    .resp_ready_o (dmi_resp_ready_o),
    .resp_i       (dmi_resp_i),
    .rdata_o      (x_rdata),
    .resp_o       (x_resp),
    .done_o       (x_done)
  );

  assign load_req_o   = (state_q == S_LOAD);
  assign busy_o       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERR);
  assign error_code_o = err_code_q;

endmodule

// File: doc/dmi_boot_sequencer.md
Name: dmi_boot_sequencer

Overview:
- Synthesizable replacement for the simulation boot flow. After reset it drives the debug module's DMI request/response port to activate the DM, select hart 0, and halt it.
- It then hands off to the memory loader, writes DPC with the boot address through an abstract command, and resumes the hart.
- It sits between the JTAG DTM mux and dm_top, and is used on FPGA/softcore builds that have no host debugger.

Parameters:
- BootAddr, 64'h8000_0080: value written to DPC.
- XLEN, 64: 32 gives a 32-bit abstract access (aarsize=2, data0 only); 64 gives aarsize=3 and writes data0 and data1.
- HartSel, 20'd0: hart index placed in dmcontrol.hartsello/hi.
- PollTimeout, 16'd4096: maximum poll responses per wait state.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse that begins the sequence; ignored unless idle
- dmi_req_valid_o  out  1  DMI request valid
- dmi_req_ready_i  in  1  DM accepts request
- dmi_req_o  out  41  {addr[6:0], op[1:0], data[31:0]}; op: 1=read, 2=write
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  always 1 while a response is awaited, else 0
- dmi_resp_i  out-of-band  34  {data[31:0], resp[1:0]}; resp≠0 is an error (direction: in)
- load_req_o  out  1  level request to the memory loader
- load_done_i  in  1  loader finished (pulse or level)
- busy_o  out  1  sequence in progress
- done_o  out  1  sticky; hart resumed at BootAddr
- error_o  out  1  sticky failure
- error_code_o  out  3  0=none, 1=DMI resp error, 2=halt timeout, 3=cmderr, 4=abstract busy timeout, 5=resume timeout

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, poll counter 0. Reset mid-sequence aborts immediately with no DMI cleanup.
- Transaction engine:
  - One outstanding transaction at a time.
  - REQ: hold valid_o and stable req_o until valid&&ready.
  - RSP: resp_ready_o=1; on resp_valid, latch data and advance.
  - Simultaneous ready and resp_valid in the same cycle is impossible by protocol; the response is only sampled in RSP.
- Step sequence (W = write, R = read):
  - S_ACT: W 0x10 = 0x0000_0001 (dmactive).
  - S_HALT: W 0x10 = haltreq(31) | hartsel | dmactive.
  - S_WHALT: R 0x11 until allhalted (bit 9); on timeout, error 2.
  - S_CLRH: W 0x10 = hartsel | dmactive.
  - S_LOAD: assert load_req_o until load_done_i, then deassert. No DMI traffic. No timeout.
  - S_D0: W 0x04 = BootAddr[31:0].
  - S_D1 (XLEN=64 only): W 0x05 = BootAddr[63:32].
  - S_CMD: W 0x17 = 0x0023_07B1 (XLEN=32) or 0x0033_07B1 (XLEN=64); transfer=1, write=1, regno=DPC.
  - S_WCMD: R 0x16 until busy (bit 12)=0. Then cmderr[10:8]≠0 gives error 3; on timeout, error 4.
  - S_RES: W 0x10 = resumereq(30) | hartsel | dmactive.
  - S_WRES: R 0x11 until allresumeack (bit 17); on timeout, error 5.
  - S_FIN: W 0x10 = hartsel | dmactive.
  - DONE: done_o=1, busy_o=0.
- Any response with resp≠0 goes to ERR with code 1. ERR sets error_o and deasserts busy_o and load_req_o.
- Poll counter:
  - Cleared on entry to each wait state; increments per response.
  - Timeout when the count reaches PollTimeout-1 without success; saturates, no wrap.
- busy_o is high in every state except IDLE, DONE, and ERR.
- start_i is ignored in DONE/ERR; only reset re-arms the block.
- Latency per DMI write is 2 cycles minimum (1 req cycle + 1 resp cycle) with zero-wait DM.

Decomposition:
- Add to dm-side package dmi_boot_pkg:
  - dmi_req_t and dmi_resp_t typedefs (or reuse dm::dmi_req_t / dm::dmi_resp_t).
  - DMI address constants: DMCONTROL=0x10, DMSTATUS=0x11, DATA0=0x04, DATA1=0x05, ABSTRACTCS=0x16, COMMAND=0x17.
  - Bit-index constants and the state enum.
- One sub-module: dmi_xact, the single-outstanding request/response engine, with a start/addr/op/wdata in, rdata/resp/done out interface. The top FSM only sequences steps.

Test Plan:
- Nominal run (XLEN=64), zero-wait DM model; allhalted on 2nd poll, load_done 50 cycles after load_req, allresumeack on 1st poll. Required:
  - Exact write order and data: 0x10←0x1, 0x10←0x8000_0001, 0x10←0x1, 0x04←0x8000_0080, 0x05←0x0, 0x17←0x0033_07B1, 0x10←0x4000_0001, 0x10←0x1.
  - done_o=1, error_o=0.
- Backpressure: dmi_req_ready_i random 30%. Required: req_o stable while valid and not ready, and the same transaction sequence as the nominal run.
- Halt never reported, PollTimeout=16. Required: exactly 16 dmstatus reads, then error_o=1, code=2, load_req_o never asserted.
- abstractcs returns busy=0, cmderr=2. Required: error code 3, and no resumereq write issued.
- DM returns resp=2 on the S_D0 write. Required: error code 1 the cycle after the response, busy_o=0.
- rst_i asserted during S_LOAD. Required: next cycle load_req_o=0, dmi_req_valid_o=0, busy_o=0. A new start_i reruns from S_ACT.
